// File: rtl/distance_pkg.sv
// Types and default constants shared by the distance filter and the display stage.
package distance_pkg;

    localparam int DIST_WIDTH    = 32;
    localparam int DEF_MAX_RANGE = 400;
    localparam int DEF_NEAR_TH   = 30;
    localparam int DEF_FAR_TH    = 40;

    typedef logic [DIST_WIDTH-1:0] dist_t;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

endpackage

// File: rtl/distance_filter_window_sum.sv
// Ring buffer of the last 2^WIN_LOG2 accepted samples with a running sum.
// sum and full describe the window including this cycle's accept, so the caller can register them directly.
module window_sum #(
    parameter int WIDTH    = 32,
    parameter int WIN_LOG2 = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      accept,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH+WIN_LOG2-1:0] sum,
    output logic                      full
);

    localparam int DEPTH = 1 << WIN_LOG2;
    localparam int SW    = WIDTH + WIN_LOG2;
    localparam logic [WIN_LOG2:0] FILL_MAX = (WIN_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]    ring [DEPTH];
    logic [WIN_LOG2-1:0] ptr;
    logic [WIN_LOG2:0]   fill;
    logic [SW-1:0]       sum_q;

    // Unfilled entries hold zero, so subtracting the overwritten entry is always safe.
    assign sum  = accept ? (sum_q + SW'(din) - SW'(ring[ptr])) : sum_q;
    assign full = (fill == FILL_MAX) || (accept && (fill == FILL_MAX - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            ptr   <= '0;
            fill  <= '0;
            for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
        end else if (flush) begin
            sum_q <= '0;
            ptr   <= '0;
            fill  <= '0;
            for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
        end else if (accept) begin
            ring[ptr] <= din;
            ptr       <= ptr + 1'b1;
            sum_q     <= sum;
            if (fill != FILL_MAX) fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/distance_filter.sv
// Range-gated moving average of ranging results with a hysteretic near flag and an idle timeout.
// Stream contract: in_valid is a one-cycle pulse with no backpressure; out_valid is a one-cycle pulse one edge after the accept.
module distance_filter
    import distance_pkg::*;
#(
    parameter int          WIDTH     = DIST_WIDTH,
    parameter int          WIN_LOG2  = 2,
    parameter int unsigned MAX_RANGE = DEF_MAX_RANGE,
    parameter int unsigned NEAR_TH   = DEF_NEAR_TH,
    parameter int unsigned FAR_TH    = DEF_FAR_TH,
    parameter int unsigned TIMEOUT   = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_distance,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_distance,
    output logic             near,
    output logic             stale,
    output logic [15:0]      dropped,
    output state_t           state_dbg
);

    localparam int IW = $clog2(TIMEOUT) + 1;
    localparam logic [IW-1:0]    IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_RANGE);
    localparam logic [WIDTH-1:0] NEAR_V    = WIDTH'(NEAR_TH);
    localparam logic [WIDTH-1:0] FAR_V     = WIDTH'(FAR_TH);

    state_t                    state, state_n;
    logic                      accept, reject, emit, flush, timeout_fire;
    logic [IW-1:0]             idle;
    logic [WIDTH+WIN_LOG2-1:0] win_sum;
    logic                      win_full;
    logic [WIDTH-1:0]          avg;

    assign accept       = in_valid && (in_distance <= MAX_V);
    assign reject       = in_valid && !accept;
    // Stale gates the timeout so the held counter never triggers a second flush.
    assign timeout_fire = !accept && !stale && (idle == IDLE_LAST);
    assign avg          = win_sum[WIDTH+WIN_LOG2-1:WIN_LOG2];
    assign state_dbg    = state;

    window_sum #(
        .WIDTH    (WIDTH),
        .WIN_LOG2 (WIN_LOG2)
    ) u_window_sum (
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
        .flush  (flush),
        .din    (in_distance),
        .sum    (win_sum),
        .full   (win_full)
    );

    always_comb begin
        state_n = state;
        emit    = 1'b0;
        flush   = 1'b0;
        if (accept) begin
            case (state)
                WARMUP: begin
                    if (win_full) begin
                        emit    = 1'b1;
                        state_n = RUN;
                    end
                end
                RUN:     emit = 1'b1;
                default: state_n = WARMUP;
            endcase
        end else if (timeout_fire) begin
            flush   = 1'b1;
            state_n = WARMUP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= WARMUP;
            out_valid    <= 1'b0;
            out_distance <= '0;
            near         <= 1'b0;
            stale        <= 1'b0;
            idle         <= '0;
            dropped      <= '0;
        end else begin
            state     <= state_n;
            out_valid <= emit;
            if (emit) begin
                out_distance <= avg;
                if (avg < NEAR_V)     near <= 1'b1;
                else if (avg > FAR_V) near <= 1'b0;
            end else if (timeout_fire) begin
                near <= 1'b0;
            end
            if (accept)            stale <= 1'b0;
            else if (timeout_fire) stale <= 1'b1;
            if (accept)                 idle <= '0;
            else if (idle != IDLE_LAST) idle <= idle + 1'b1;
            if (reject && (dropped != 16'hFFFF)) dropped <= dropped + 1'b1;
        end
    end

endmodule

// File: tb/tb_distance_filter.sv
// Directed bench for distance_filter: expected averages are queued at issue time and checked by a monitor.
module tb_distance_filter;
    import distance_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_distance;
    logic        out_valid;
    logic [31:0] out_distance;
    logic        near;
    logic        stale;
    logic [15:0] dropped;
    state_t      state_dbg;

    int          total = 0;
    int          bad   = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    distance_filter #(
        .TIMEOUT (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_distance  (in_distance),
        .out_valid    (out_valid),
        .out_distance (out_distance),
        .near         (near),
        .stale        (stale),
        .dropped      (dropped),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic near_e, input logic [31:0] avg_e);
        exp_q.push_back({near_e, avg_e});
    endtask

    // Drive one sample for exactly one edge; returns 1 time unit after that edge.
    task automatic send(input logic [31:0] d);
        in_valid    = 1'b1;
        in_distance = d;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_distance = '0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_distance"}, out_distance, 32'd0);
        chk({tag, "_near"}, 32'(near), 32'd0);
        chk({tag, "_stale"}, 32'(stale), 32'd0);
        chk({tag, "_dropped"}, 32'(dropped), 32'd0);
        chk({tag, "_state"}, 32'(state_dbg), 32'(WARMUP));
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got avg %0d with no expected result", out_distance);
            end else begin
                mon_e = exp_q.pop_front();
                chk("avg", out_distance, mon_e[31:0]);
                chk("near", 32'(near), 32'(mon_e[32]));
            end
        end
    end

    initial begin
        #100000;
        total++;
        bad++;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_distance = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // Warm-up, then sliding window with hysteresis.
        send(10);
        send(20);
        send(30);
        push(1'b1, 25); send(40);
        push(1'b1, 35); send(50);
        push(1'b0, 45); send(60);
        push(1'b0, 55); send(70);

        // Range gate: one over the limit, one exactly at it.
        send(401);
        chk("dropped_after_401", 32'(dropped), 32'd1);
        push(1'b0, 145); send(400);
        push(1'b0, 133); send(4);
        push(1'b0, 119); send(4);
        push(1'b0, 103); send(4);
        push(1'b1, 4);   send(4);

        // Timeout: 100 idle edges after the last accept.
        repeat (99) @(posedge clk);
        #1;
        chk("stale_before_timeout", 32'(stale), 32'd0);
        @(posedge clk);
        #1;
        chk("stale_at_timeout", 32'(stale), 32'd1);
        chk("near_at_timeout", 32'(near), 32'd0);
        chk("state_at_timeout", 32'(state_dbg), 32'(WARMUP));
        chk("avg_held_at_timeout", out_distance, 32'd4);
        repeat (20) @(posedge clk);
        #1;
        chk("stale_held", 32'(stale), 32'd1);

        // Fresh warm-up after flush.
        send(8);
        chk("stale_cleared", 32'(stale), 32'd0);
        chk("state_rewarm", 32'(state_dbg), 32'(WARMUP));
        send(8);
        send(8);
        push(1'b1, 8); send(8);

        // Accept lands on the exact timeout edge.
        repeat (99) @(posedge clk);
        #1;
        chk("stale_pre_collision", 32'(stale), 32'd0);
        push(1'b1, 31); send(100);
        chk("stale_collision", 32'(stale), 32'd0);
        chk("state_collision", 32'(state_dbg), 32'(RUN));

        // Threshold boundaries and truncation.
        push(1'b0, 45); send(64);
        push(1'b0, 43); send(0);
        push(1'b0, 41); send(0);
        push(1'b0, 30); send(56);
        push(1'b1, 29); send(60);
        push(1'b1, 40); send(44);
        push(1'b0, 50); send(43);
        push(1'b0, 36); send(0);
        push(1'b1, 21); send(0);
        @(negedge clk);
        #1;
        chk("near_before_reset", 32'(near), 32'd1);

        // Asynchronous reset between edges.
        rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(5);
        send(5);
        send(5);
        repeat (5) @(posedge clk);
        #1;
        chk("state_after_reset_warmup", 32'(state_dbg), 32'(WARMUP));
        chk("pending_expected", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
